booth_radix2_mul: RTL and testbench



---
 rtl/booth_radix2_mul.sv | 110 +++++++++++
 tb/tb_booth_radix2_mul.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/booth_radix2_mul.sv
// rtl/booth_radix2_mul.sv - sequential signed Booth radix-2 multiplier, one recoded bit per clock
module booth_radix2_mul #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;

  // a and m carry one guard bit so that m = -2^(W-1) never overflows the add/subtract
  logic [W:0]    a;
  logic [W:0]    m;
  logic [W-1:0]  q;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic [W:0]    a_sum;
  logic [W:0]    a_sh;
  logic [W-1:0]  q_sh;

  // state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are pure decodes of the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Booth add/subtract selected by {q[0], q_m1}, then arithmetic right shift of {a, q, q_m1}
  always_comb begin
    unique case ({q[0], q_m1})
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a + ~m + (W+1)'(1);
      default: a_sum = a;
    endcase
    a_sh = {a_sum[W], a_sum[W:1]};
    q_sh = {a_sum[0], q[W-1:1]};
  end

  // datapath: operand capture, iteration and result latch
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a    <= '0;
            m    <= {x[W-1], x};
            q    <= y;
            q_m1 <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a    <= a_sh;
          q    <= q_sh;
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= {a_sh[W-1:0], q_sh};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix2_mul.sv
// tb/tb_booth_radix2_mul.sv - self-checking bench for booth_radix2_mul at W=8 and W=4
module tb_booth_radix2_mul;

  logic        clk;
  logic        rst_b;
  logic        start8, start4;
  logic [7:0]  x8, y8;
  logic [3:0]  x4, y4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] prod8;
  logic [7:0]  prod4;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [8];

  booth_radix2_mul #(.W(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_radix2_mul #(.W(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .start(start4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic cur_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  function automatic logic [15:0] cur_prod(input int w);
    return (w == 8) ? prod8 : {{8{prod4[7]}}, prod4};
  endfunction

  // one full transaction; tok clears on any busy/done timing deviation
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output logic tok);
    tok = 1'b1;
    @(negedge clk);
    if (w == 8) begin start8 = 1'b1; x8 = a; y8 = b; end
    else begin start4 = 1'b1; x4 = a[3:0]; y4 = b[3:0]; end
    @(negedge clk);
    start8 = 1'b0; start4 = 1'b0;
    x8 = 8'($urandom); y8 = 8'($urandom);
    x4 = 4'($urandom); y4 = 4'($urandom);
    for (int k = 0; k < w; k++) begin
      if (!(cur_busy(w) === 1'b1 && cur_done(w) === 1'b0)) tok = 1'b0;
      @(negedge clk);
    end
    if (!(cur_busy(w) === 1'b1 && cur_done(w) === 1'b1)) tok = 1'b0;
    p = cur_prod(w);
    @(negedge clk);
    if (cur_busy(w) !== 1'b0 || cur_done(w) !== 1'b0) tok = 1'b0;
    if (cur_prod(w) !== p) tok = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    logic        tok;
    logic [7:0]  ra, rb;
    int          ia, ib, dcnt;
    logic [15:0] exp16;

    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{8'h05, 8'hFD, 16'hFFF1};
    vecs[3] = '{8'hF9, 8'hFA, 16'h002A};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'h80, 8'h7F, 16'hC080};
    vecs[6] = '{8'h00, 8'h5A, 16'h0000};
    vecs[7] = '{8'h7F, 8'h7F, 16'h3F01};

    rst_b = 1'b0; start8 = 1'b0; start4 = 1'b0;
    x8 = '0; y8 = '0; x4 = '0; y4 = '0;
    #12;
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_done8", 32'(done8), 32'd0);
    check("reset_prod8", 32'(prod8), 32'd0);
    check("reset_prod4", 32'(prod4), 32'd0);
    #5 rst_b = 1'b1;

    // basic transaction plus hold of the result afterwards
    run_op(8, 8'd3, 8'd5, p, tok);
    check("t1_prod", 32'(p), 32'h000F);
    check("t1_timing", 32'(tok), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_held", 32'(prod8), 32'h000F);

    for (int i = 0; i < 8; i++) begin
      run_op(8, vecs[i].x, vecs[i].y, p, tok);
      check($sformatf("vec%0d_prod", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("vec%0d_timing", i), 32'(tok), 32'd1);
    end

    // start held high with changing operands: one result, then a fresh accept
    @(negedge clk);
    start8 = 1'b1; x8 = 8'd3; y8 = 8'd5;
    @(negedge clk);
    x8 = 8'd9; y8 = 8'd9;
    dcnt = 0;
    for (int k = 0; k <= 8; k++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    check("t4_done_count", 32'(dcnt), 32'd1);
    check("t4_prod", 32'(prod8), 32'h000F);
    check("t4_idle", 32'(busy8), 32'd0);
    @(negedge clk);
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_second_done", 32'(done8), 32'd1);
    check("t4_second_prod", 32'(prod8), 32'h0051);
    @(negedge clk);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    start8 = 1'b1; x8 = 8'd3; y8 = 8'd5;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_prod", 32'(prod8), 32'd0);
    @(negedge clk);
    #2 rst_b = 1'b1;
    run_op(8, 8'd2, 8'd2, p, tok);
    check("t5_after_prod", 32'(p), 32'h0004);
    check("t5_after_timing", 32'(tok), 32'd1);

    // reference-model comparison over random signed pairs at both widths
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ia = $signed(ra); ib = $signed(rb);
      exp16 = 16'(ia * ib);
      run_op(8, ra, rb, p, tok);
      check($sformatf("rand8_%0d_prod", i), 32'(p), 32'(exp16));
      check($sformatf("rand8_%0d_timing", i), 32'(tok), 32'd1);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15));
      ia = $signed(ra[3:0]); ib = $signed(rb[3:0]);
      exp16 = 16'(ia * ib);
      run_op(4, ra, rb, p, tok);
      check($sformatf("rand4_%0d_prod", i), 32'(p), 32'(exp16));
      check($sformatf("rand4_%0d_timing", i), 32'(tok), 32'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
